button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Sits directly downstream of the debounce stage and consumes its clean, same-clock `result` level on `btn_db`.
- Classifies button activity into single-cycle event pulses (short press, long press, double click), a held level and a wrapping press counter.
- Feeds the UI/control logic, which then works with events rather than raw levels.

Parameters:
- LONG_CYCLES, 50000000: cycles button must stay high to qualify as a long press; must be >= 2.
- DCLICK_CYCLES, 12500000: window after release in which a second press makes a double click; must be >= 2.
- REPEAT_CYCLES, 10000000: auto-repeat period; used only with the optional feature; must be >= 2.
- TIMER_W, 26: timer width; must hold max(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES) - 1.
- COUNT_W, 8: press counter width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_db  in  1  debounced button level, synchronous to clk, high = pressed.
- short_press  out  1  one-cycle pulse.
- long_press  out  1  one-cycle pulse.
- double_click  out  1  one-cycle pulse.
- held  out  1  level, high while in LONG_HELD.
- press_count  out  COUNT_W  number of accepted presses, wraps modulo 2^COUNT_W.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; timer, btn_prev and press_count = 0.
  - All outputs 0 immediately.
  - Reset mid-operation abandons the event in progress; no pulse is emitted.
- Edge detect:
  - btn_prev registers btn_db every edge.
  - rise = btn_db & ~btn_prev; fall = ~btn_db & btn_prev.
  - Because btn_prev resets to 0, btn_db high at reset release counts as a press on the first edge.
- press_count: increments on every edge where rise = 1, in any state; wraps silently.
- Output registers: all outputs are registered. Each pulse is high for exactly the one cycle following the edge that triggers it. At most one of the three pulses is high in any cycle.
- FSM (evaluated every rising clk edge):
  - IDLE: rise -> PRESSED, timer = 0.
  - PRESSED:
    - fall -> WAIT_SECOND, timer = 0.
    - else if timer == LONG_CYCLES-1 -> LONG_HELD, long_press pulse.
    - else timer++.
    - Net effect: long_press is high in the cycle after the LONG_CYCLES-th edge following the first edge that sampled btn_db high.
  - LONG_HELD:
    - held = 1.
    - fall -> IDLE, with held dropping to 0 the cycle after the fall edge.
    - No short_press or double_click is ever generated from a long press.
  - WAIT_SECOND:
    - rise -> SECOND_PRESSED, double_click pulse.
    - else if timer == DCLICK_CYCLES-1 -> IDLE, short_press pulse.
    - else timer++.
    - Rise wins over timeout on the same edge.
    - short_press is high in the cycle after the DCLICK_CYCLES-th edge following the fall edge.
  - SECOND_PRESSED:
    - fall -> IDLE.
    - No timer, no further events, however long the button is held.
- Timer: saturating behaviour is not required; it is cleared on every state entry that uses it.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - In LONG_HELD, the timer clears on entry and counts each edge while btn_db is high.
  - When timer == REPEAT_CYCLES-1, long_press pulses again and the timer clears.
  - Pulses therefore occur after edges LONG_CYCLES, LONG_CYCLES+REPEAT_CYCLES, and so on.
  - A fall stops repeats immediately.
- Undefined: exactly one long_press per hold; REPEAT_CYCLES is unused.

Test Plan:
Bench parameters: LONG_CYCLES=10, DCLICK_CYCLES=6, REPEAT_CYCLES=4, COUNT_W=4.
- Short press: btn_db high 3 cycles, then low 10 -> short_press high exactly 1 cycle, after the 6th edge past the fall; press_count=1; long_press and double_click stay 0.
- Long press: btn_db high 15 cycles -> long_press pulse after edge 10; held=1 until the cycle after the fall; no short_press. With BTN_AUTOREPEAT_EN and 20-cycle hold -> long_press pulses after edges 10, 14 and 18.
- Double click: high 2, low 3, high 2, low 10 -> double_click pulse the cycle after the second rise edge; no short_press; press_count=2.
- Boundary: second rise sampled on the same edge that timer reaches 5 in WAIT_SECOND -> double_click=1, short_press=0.
- Reset mid-operation: assert rst_n low asynchronously (between clock edges) at cycle 5 of a hold -> all outputs 0 at once; after release with btn_db low, no pulse ever appears.
- Counter wrap: 17 isolated short presses -> press_count=1; exactly 17 short_press pulses.

Source files
------------

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into short/long/double-click pulses, a held level and a press counter.
// Optional auto-repeat of long_press while held: define BTN_AUTOREPEAT_EN.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int DCLICK_CYCLES = 12500000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int TIMER_W       = 26,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_db,
  output logic               short_press,
  output logic               long_press,
  output logic               double_click,
  output logic               held,
  output logic [COUNT_W-1:0] press_count
);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_t;

  localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DCLICK_LAST = TIMER_W'(DCLICK_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);
`endif

  // Reject configurations the timer cannot represent at elaboration time.
  if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      longint'(LONG_CYCLES) > (longint'(1) << TIMER_W) ||
      longint'(DCLICK_CYCLES) > (longint'(1) << TIMER_W) ||
      longint'(REPEAT_CYCLES) > (longint'(1) << TIMER_W)) begin : g_bad_params
    $error("button_event_decoder: invalid cycle parameters for TIMER_W");
  end

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic               btn_prev;
  logic               rise, fall;
  logic               short_nxt, long_nxt, dclick_nxt, held_nxt;

  assign rise = btn_db & ~btn_prev;
  assign fall = ~btn_db & btn_prev;

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    dclick_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESSED;
          timer_nxt = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_nxt = WAIT_SECOND;
          timer_nxt = '0;
        end else if (timer == LONG_LAST) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_nxt = IDLE;
`ifdef BTN_AUTOREPEAT_EN
        end else if (btn_db) begin
          if (timer == REPEAT_LAST) begin
            long_nxt  = 1'b1;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + TIMER_W'(1);
          end
`endif
        end
      end
      // A rise on the timeout edge still counts as the second click.
      WAIT_SECOND: begin
        if (rise) begin
          state_nxt  = SECOND_PRESSED;
          dclick_nxt = 1'b1;
        end else if (timer == DCLICK_LAST) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      SECOND_PRESSED: begin
        if (fall) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    held_nxt = (state_nxt == LONG_HELD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      btn_prev     <= 1'b0;
      press_count  <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      btn_prev     <= btn_db;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_click <= dclick_nxt;
      held         <= held_nxt;
      if (rise) begin
        press_count <= press_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: scenario table, reset/wrap sequences and random levels vs. an index-based model.
module tb_button_event_decoder;
  localparam int L  = 10;
  localparam int D  = 6;
  localparam int R  = 4;
  localparam int TW = 4;
  localparam int CW = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_db;
  logic          short_press, long_press, double_click, held;
  logic [CW-1:0] press_count;

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_CYCLES(L), .DCLICK_CYCLES(D), .REPEAT_CYCLES(R), .TIMER_W(TW), .COUNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_db(btn_db),
    .short_press(short_press), .long_press(long_press), .double_click(double_click),
    .held(held), .press_count(press_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int tally_short = 0, tally_long = 0, tally_dclick = 0;

  // Reference model: edge indices of the current press and last release.
  int            n, press_start, fall_idx;
  bit            m_prev, is_second, long_done, pending;
  logic [CW-1:0] exp_count;
  bit            e_short, e_long, e_dc, e_held;

  typedef struct {
    int    h1, l1, h2, l2;
    int    n_short, n_long, n_dclick, n_press;
    string name;
  } scen_t;
  scen_t scen[9];

  task automatic model_reset();
    n = 0; press_start = 0; fall_idx = 0;
    m_prev = 0; is_second = 0; long_done = 0; pending = 0;
    exp_count = '0;
    e_short = 0; e_long = 0; e_dc = 0; e_held = 0;
  endtask

  task automatic model_step(input bit b);
    bit rise, fall;
    int k;
    n++;
    rise = b && !m_prev;
    fall = !b && m_prev;
    e_short = 0; e_long = 0; e_dc = 0;
    if (rise) begin
      exp_count = exp_count + 1'b1;
      if (pending && (n - fall_idx) <= D) begin
        e_dc = 1; is_second = 1; pending = 0;
      end else begin
        is_second = 0; long_done = 0; press_start = n;
      end
    end else if (b && !is_second) begin
      k = n - press_start;
      if (k == L) begin
        e_long = 1; long_done = 1;
      end else if (AR == 1 && k > L && ((k - L) % R) == 0) begin
        e_long = 1;
      end
    end else if (fall) begin
      if (!is_second && !long_done) begin
        pending = 1; fall_idx = n;
      end
    end else if (!b && pending && (n - fall_idx) == D) begin
      e_short = 1; pending = 0;
    end
    e_held = b && !is_second && long_done;
    m_prev = b;
  endtask

  task automatic checkOutput(input string name);
    logic [CW+3:0] act, expv;
    act  = {short_press, long_press, double_click, held, press_count};
    expv = {e_short, e_long, e_dc, e_held, exp_count};
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t: got s=%b l=%b d=%b h=%b cnt=%0d, expected s=%b l=%b d=%b h=%b cnt=%0d",
               name, $time, act[CW+3], act[CW+2], act[CW+1], act[CW], act[CW-1:0],
               expv[CW+3], expv[CW+2], expv[CW+1], expv[CW], expv[CW-1:0]);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Entered and left at a falling clock edge; one model step per rising edge.
  task automatic applyStimulus(input bit b, input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      btn_db = b;
      @(posedge clk);
      model_step(b);
      #1;
      tally_short  += int'(short_press);
      tally_long   += int'(long_press);
      tally_dclick += int'(double_click);
      checkOutput(name);
      @(negedge clk);
    end
  endtask

  initial begin
    int s0, l0, d0;
    logic [CW-1:0] c0;

    scen[0] = '{3, 10, 0, 0, 1, 0, 0, 1, "short"};
    scen[1] = '{15, 10, 0, 0, 0, 1 + AR, 0, 1, "long15"};
    scen[2] = '{2, 3, 2, 10, 0, 0, 1, 2, "double"};
    scen[3] = '{2, 6, 2, 10, 0, 0, 1, 2, "dclick_at_timeout"};
    scen[4] = '{2, 7, 2, 10, 2, 0, 0, 2, "dclick_too_late"};
    scen[5] = '{10, 10, 0, 0, 1, 0, 0, 1, "hold_L_short"};
    scen[6] = '{11, 10, 0, 0, 0, 1, 0, 1, "hold_L1_long"};
    scen[7] = '{20, 10, 0, 0, 0, 1 + 2 * AR, 0, 1, "long20"};
    scen[8] = '{2, 3, 30, 10, 0, 0, 1, 2, "double_long_second"};

    rst_n = 1'b1;
    btn_db = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      s0 = tally_short; l0 = tally_long; d0 = tally_dclick; c0 = press_count;
      applyStimulus(1'b1, scen[i].h1, scen[i].name);
      applyStimulus(1'b0, scen[i].l1, scen[i].name);
      applyStimulus(1'b1, scen[i].h2, scen[i].name);
      applyStimulus(1'b0, scen[i].l2, scen[i].name);
      checkValue({scen[i].name, "_short_n"},  tally_short - s0,  scen[i].n_short);
      checkValue({scen[i].name, "_long_n"},   tally_long - l0,   scen[i].n_long);
      checkValue({scen[i].name, "_dclick_n"}, tally_dclick - d0, scen[i].n_dclick);
      checkValue({scen[i].name, "_press_n"},  int'(CW'(press_count - c0)), scen[i].n_press);
    end

    // Button already high when reset is released counts as a press.
    btn_db = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1 checkOutput("reset_btn_high");
    @(negedge clk);
    rst_n = 1'b1;
    s0 = tally_short;
    applyStimulus(1'b1, 3, "release_high");
    applyStimulus(1'b0, 10, "release_high");
    checkValue("release_high_short_n", tally_short - s0, 1);
    checkValue("release_high_count", int'(press_count), 1);

    // Asynchronous reset in the middle of a hold abandons the press.
    applyStimulus(1'b1, 5, "midop_hold");
    #2 rst_n = 1'b0;
    model_reset();
    #1 checkOutput("reset_midop");
    btn_db = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = tally_short; l0 = tally_long; d0 = tally_dclick;
    applyStimulus(1'b0, 20, "post_reset");
    checkValue("post_reset_pulses", (tally_short - s0) + (tally_long - l0) + (tally_dclick - d0), 0);

    s0 = tally_short;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 3, "wrap");
      applyStimulus(1'b0, 10, "wrap");
    end
    checkValue("wrap_short_n", tally_short - s0, 17);
    checkValue("wrap_count", int'(press_count), 1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)), "random");
    end
    applyStimulus(1'b0, 12, "random_tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
